// File: rtl/fixed_point_pkg.sv
// Shared Q16.16 sign-magnitude constants, helpers and the LIF stepper state type.
package fixed_point_pkg;

  localparam int unsigned N = 32;
  localparam int unsigned Q = 16;

  localparam logic [N-1:0] FP_ONE  = 32'h0001_0000;
  localparam logic [N-1:0] FP_ZERO = '0;

  typedef enum logic [2:0] {
    StIdle,
    StLeak,
    StSum,
    StScale,
    StAcc,
    StDone
  } lif_state_t;

  // Fold sign-magnitude negative zero onto the single canonical zero.
  function automatic logic [N-1:0] norm_zero(input logic [N-1:0] x);
    norm_zero = (x[N-2:0] == '0) ? FP_ZERO : x;
  endfunction

endpackage

// File: rtl/add.sv
// Sign-magnitude adder; magnitude wraps modulo 2^(N-1), no saturation.
module add #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_y
);

  logic [N-2:0] w_ma;
  logic [N-2:0] w_mb;
  logic [N-2:0] w_mag;
  logic         w_sign;

  assign w_ma = i_a[N-2:0];
  assign w_mb = i_b[N-2:0];

  always_comb begin
    w_mag  = w_ma + w_mb;
    w_sign = i_a[N-1];
    if (i_a[N-1] != i_b[N-1]) begin
      // Opposite signs: subtract the smaller magnitude, keep the larger operand's sign.
      if (w_ma >= w_mb) begin
        w_mag  = w_ma - w_mb;
        w_sign = i_a[N-1];
      end else begin
        w_mag  = w_mb - w_ma;
        w_sign = i_b[N-1];
      end
    end
  end

  assign o_y = {w_sign, w_mag};

endmodule

// File: rtl/fixed_point_cmp.sv
// Sign-magnitude comparator; +0 and -0 compare equal.
module fixed_point_cmp #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_gt,
  output logic         o_eq,
  output logic         o_lt
);

  logic [N-2:0] w_ma;
  logic [N-2:0] w_mb;
  logic         w_sa;
  logic         w_sb;

  assign w_ma = i_a[N-2:0];
  assign w_mb = i_b[N-2:0];
  assign w_sa = i_a[N-1];
  assign w_sb = i_b[N-1];

  always_comb begin
    o_gt = 1'b0;
    o_eq = 1'b0;
    o_lt = 1'b0;
    if (w_ma == '0 && w_mb == '0) begin
      o_eq = 1'b1;
    end else if (w_sa != w_sb) begin
      o_gt = ~w_sa;
      o_lt = w_sa;
    end else if (w_ma == w_mb) begin
      o_eq = 1'b1;
    end else if ((w_ma > w_mb) ^ w_sa) begin
      // Larger magnitude wins for positives, loses for negatives.
      o_gt = 1'b1;
    end else begin
      o_lt = 1'b1;
    end
  end

endmodule

// File: rtl/mult.sv
// Sign-magnitude fixed-point multiplier; keeps product magnitude bits [N-2+Q:Q].
module mult #(
  parameter int unsigned N = 32,
  parameter int unsigned Q = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_y
);

  localparam int unsigned PW = N - 1 + Q;

  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_b_ext;
  logic [PW-1:0] w_prod;
  logic          w_unused_lsb;

  assign w_a_ext = {{Q{1'b0}}, i_a[N-2:0]};
  assign w_b_ext = {{Q{1'b0}}, i_b[N-2:0]};
  // Computing in PW bits discards exactly the magnitude bits above N-2+Q.
  assign w_prod  = w_a_ext * w_b_ext;

  assign o_y          = {i_a[N-1] ^ i_b[N-1], w_prod[PW-1:Q]};
  assign w_unused_lsb = ^w_prod[Q-1:0];

endmodule

// File: rtl/negator.sv
// Sign-magnitude negation: flips the sign bit only.
module negator #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] i_a,
  output logic [N-1:0] o_y
);

  assign o_y = {~i_a[N-1], i_a[N-2:0]};

endmodule

// File: rtl/lif_euler_stepper.sv
// Leaky integrate-and-fire membrane stepper: one forward-Euler step per accepted sample,
// time-multiplexing a single add, mult, negator and comparator.
module lif_euler_stepper
  import fixed_point_pkg::*;
#(
  parameter int unsigned REF_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     i_in,
  input  logic [N-1:0]     v_rest,
  input  logic [N-1:0]     v_reset,
  input  logic [N-1:0]     v_th,
  input  logic [N-1:0]     r,
  input  logic [N-1:0]     dt_over_tau,
  input  logic [REF_W-1:0] t_ref,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     v_out,
  output logic             spike
);

  lif_state_t r_state;

  logic [N-1:0]     r_i_in;
  logic [N-1:0]     r_v_rest;
  logic [N-1:0]     r_v_reset;
  logic [N-1:0]     r_v_th;
  logic [N-1:0]     r_r;
  logic [N-1:0]     r_dt;
  logic [REF_W-1:0] r_t_ref;

  logic [N-1:0]     r_leak;
  logic [N-1:0]     r_drive;
  logic [N-1:0]     r_sum;
  logic [N-1:0]     r_delta;
  logic [N-1:0]     r_v;
  logic [REF_W-1:0] r_ref_cnt;
  logic             r_spike;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [N-1:0] w_neg_in;
  logic [N-1:0] w_neg_y;
  logic [N-1:0] w_add_a;
  logic [N-1:0] w_add_b;
  logic [N-1:0] w_add_y;
  logic [N-1:0] w_mult_a;
  logic [N-1:0] w_mult_b;
  logic [N-1:0] w_mult_y;
  logic [N-1:0] w_v_next;
  logic         w_cmp_gt;
  logic         w_cmp_eq;
  logic         w_unused_lt;
  logic         w_fire;

  // Operand steering: LEAK uses add+mult, SUM add+negator, SCALE mult, ACC add+cmp.
  always_comb begin
    w_neg_in = r_v_rest;
    w_add_a  = r_v;
    w_add_b  = w_neg_y;
    w_mult_a = r_r;
    w_mult_b = r_i_in;
    unique case (r_state)
      StSum: begin
        w_neg_in = r_leak;
        w_add_a  = r_drive;
        w_add_b  = w_neg_y;
      end
      StScale: begin
        w_mult_a = r_sum;
        w_mult_b = r_dt;
      end
      StAcc: begin
        w_add_a = r_v;
        w_add_b = r_delta;
      end
      default: ;
    endcase
  end

  negator #(.N(N)) u_negator (
    .i_a (w_neg_in),
    .o_y (w_neg_y)
  );

  add #(.N(N)) u_add (
    .i_a (w_add_a),
    .i_b (w_add_b),
    .o_y (w_add_y)
  );

  mult #(.N(N), .Q(Q)) u_mult (
    .i_a (w_mult_a),
    .i_b (w_mult_b),
    .o_y (w_mult_y)
  );

  assign w_v_next = norm_zero(w_add_y);

  fixed_point_cmp #(.N(N)) u_cmp (
    .i_a  (w_v_next),
    .i_b  (r_v_th),
    .o_gt (w_cmp_gt),
    .o_eq (w_cmp_eq),
    .o_lt (w_unused_lt)
  );

  assign w_fire = w_cmp_gt | w_cmp_eq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_i_in      <= '0;
      r_v_rest    <= '0;
      r_v_reset   <= '0;
      r_v_th      <= '0;
      r_r         <= '0;
      r_dt        <= '0;
      r_t_ref     <= '0;
      r_leak      <= '0;
      r_drive     <= '0;
      r_sum       <= '0;
      r_delta     <= '0;
      r_v         <= '0;
      r_ref_cnt   <= '0;
      r_spike     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_i_in     <= i_in;
            r_v_rest   <= v_rest;
            r_v_reset  <= v_reset;
            r_v_th     <= v_th;
            r_r        <= r;
            r_dt       <= dt_over_tau;
            r_t_ref    <= t_ref;
            r_in_ready <= 1'b0;
            r_state    <= StLeak;
          end
        end
        StLeak: begin
          r_leak  <= norm_zero(w_add_y);
          r_drive <= norm_zero(w_mult_y);
          r_state <= StSum;
        end
        StSum: begin
          r_sum   <= norm_zero(w_add_y);
          r_state <= StScale;
        end
        StScale: begin
          r_delta <= norm_zero(w_mult_y);
          r_state <= StAcc;
        end
        StAcc: begin
          // Refractory steps still take the full pipeline so latency stays fixed.
          if (r_ref_cnt != '0) begin
            r_v       <= norm_zero(r_v_reset);
            r_spike   <= 1'b0;
            r_ref_cnt <= r_ref_cnt - REF_W'(1);
          end else if (w_fire) begin
            r_v       <= norm_zero(r_v_reset);
            r_spike   <= 1'b1;
            r_ref_cnt <= r_t_ref;
          end else begin
            r_v     <= w_v_next;
            r_spike <= 1'b0;
          end
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign v_out     = r_v;
  assign spike     = r_spike;

endmodule

// File: tb/tb_lif_euler_stepper.sv
// Scenario-driven bench for lif_euler_stepper with a queue of expected step results.
module tb_lif_euler_stepper;

  localparam int unsigned N     = 32;
  localparam int unsigned REF_W = 8;

  localparam logic [N-1:0] ONE  = 32'h0001_0000;
  localparam logic [N-1:0] HALF = 32'h0000_8000;
  localparam logic [N-1:0] TWO  = 32'h0002_0000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     i_in = '0;
  logic [N-1:0]     v_rest = '0;
  logic [N-1:0]     v_reset = '0;
  logic [N-1:0]     v_th = '0;
  logic [N-1:0]     r_val = '0;
  logic [N-1:0]     dt_over_tau = '0;
  logic [REF_W-1:0] t_ref = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     v_out;
  logic             spike;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0] v;
    logic         sp;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  lif_euler_stepper #(.REF_W(REF_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .i_in        (i_in),
    .v_rest      (v_rest),
    .v_reset     (v_reset),
    .v_th        (v_th),
    .r           (r_val),
    .dt_over_tau (dt_over_tau),
    .t_ref       (t_ref),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .v_out       (v_out),
    .spike       (spike)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic set_cfg(input logic [N-1:0] vrest, input logic [N-1:0] vres,
                         input logic [N-1:0] vth, input logic [N-1:0] rr,
                         input logic [N-1:0] dt, input logic [REF_W-1:0] tr);
    v_rest      = vrest;
    v_reset     = vres;
    v_th        = vth;
    r_val       = rr;
    dt_over_tau = dt;
    t_ref       = tr;
  endtask

  task automatic push_exp(input logic [N-1:0] v, input logic sp);
    exp_t e;
    e.v  = v;
    e.sp = sp;
    sb_q.push_back(e);
  endtask

  // Offers one sample, waits (bounded) for the result, consumes it. lat counts edges after accept.
  task automatic do_step(input logic [N-1:0] cur, output logic [N-1:0] v, output logic sp,
                         output int lat);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      cycle();
      w++;
    end
    i_in     = cur;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      cycle();
      lat++;
    end
    v         = v_out;
    sp        = spike;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (spike !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_spike: got %b want 0", spike);
    end
    n_checks++;
    if (v_out !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL reset_v_out: got %h want 00000000", v_out);
    end
  endtask

  task automatic test_single_step();
    logic [N-1:0] v;
    logic         sp;
    int           lat;
    exp_t         e;
    apply_reset();
    set_cfg('0, '0, 32'h000A_0000, ONE, HALF, 8'd0);
    push_exp(32'h0001_0000, 1'b0);
    do_step(TWO, v, sp, lat);
    e = sb_q.pop_front();
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL single_latency: got %0d edges want 4", lat);
    end
    n_checks++;
    if (v !== e.v) begin
      n_fail++;
      $display("FAIL single_v_out: got %h want %h", v, e.v);
    end
    n_checks++;
    if (sp !== e.sp) begin
      n_fail++;
      $display("FAIL single_spike: got %b want %b", sp, e.sp);
    end
  endtask

  task automatic test_threshold_refractory();
    logic [N-1:0] v;
    logic         sp;
    int           lat;
    exp_t         e;
    apply_reset();
    set_cfg('0, '0, 32'h0001_8000, ONE, HALF, 8'd2);
    push_exp(32'h0001_0000, 1'b0);
    push_exp(32'h0000_0000, 1'b1);
    push_exp(32'h0000_0000, 1'b0);
    push_exp(32'h0000_0000, 1'b0);
    push_exp(32'h0001_0000, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      do_step(TWO, v, sp, lat);
      e = sb_q.pop_front();
      n_checks++;
      if (lat !== 4) begin
        n_fail++;
        $display("FAIL thresh_latency step%0d: got %0d want 4", k, lat);
      end
      n_checks++;
      if (v !== e.v) begin
        n_fail++;
        $display("FAIL thresh_v_out step%0d: got %h want %h", k, v, e.v);
      end
      n_checks++;
      if (sp !== e.sp) begin
        n_fail++;
        $display("FAIL thresh_spike step%0d: got %b want %b", k, sp, e.sp);
      end
    end
  endtask

  task automatic test_sign();
    logic [N-1:0] v;
    logic         sp;
    int           lat;
    exp_t         e;
    apply_reset();
    set_cfg('0, '0, 32'h000A_0000, ONE, HALF, 8'd0);
    push_exp(32'h8001_0000, 1'b0);
    push_exp(32'h0000_8000, 1'b0);
    do_step(32'h8002_0000, v, sp, lat);
    e = sb_q.pop_front();
    n_checks++;
    if (v !== e.v || sp !== e.sp) begin
      n_fail++;
      $display("FAIL sign_neg_step: got %h/%b want %h/%b", v, sp, e.v, e.sp);
    end
    do_step(TWO, v, sp, lat);
    e = sb_q.pop_front();
    n_checks++;
    if (v !== e.v || sp !== e.sp) begin
      n_fail++;
      $display("FAIL sign_recover_step: got %h/%b want %h/%b", v, sp, e.v, e.sp);
    end
  endtask

  task automatic test_neg_zero();
    logic [N-1:0] v;
    logic         sp;
    int           lat;
    exp_t         e;
    apply_reset();
    set_cfg('0, '0, 32'h000A_0000, ONE, HALF, 8'd0);
    push_exp(32'h0000_0000, 1'b0);
    do_step(32'h8000_0000, v, sp, lat);
    e = sb_q.pop_front();
    n_checks++;
    if (v !== e.v) begin
      n_fail++;
      $display("FAIL neg_zero_v_out: got %h want %h", v, e.v);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] v;
    logic         sp;
    int           lat;
    exp_t         e;
    apply_reset();
    set_cfg('0, '0, 32'h000A_0000, ONE, HALF, 8'd0);
    push_exp(32'h0001_0000, 1'b0);
    i_in     = TWO;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      cycle();
      lat++;
    end
    e = sb_q.pop_front();
    n_checks++;
    if (v_out !== e.v || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first_result: got %h valid %b want %h valid 1", v_out, out_valid, e.v);
    end
    i_in     = 32'h0005_0000;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || v_out !== e.v || spike !== e.sp || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle%0d: got valid %b v %h spike %b ready %b want 1 %h %b 0",
                 k, out_valid, v_out, spike, in_ready, e.v, e.sp);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got valid %b ready %b want 0 1", out_valid, in_ready);
    end
    // The sample offered during the hold must not have advanced v.
    push_exp(32'h0001_8000, 1'b0);
    do_step(TWO, v, sp, lat);
    e = sb_q.pop_front();
    n_checks++;
    if (v !== e.v) begin
      n_fail++;
      $display("FAIL bp_next_step: got %h want %h", v, e.v);
    end
  endtask

  task automatic test_reset_mid_step();
    logic [N-1:0] v;
    logic         sp;
    int           lat;
    exp_t         e;
    bit           seen_valid;
    apply_reset();
    set_cfg('0, '0, 32'h000A_0000, ONE, HALF, 8'd0);
    push_exp(32'h0001_0000, 1'b0);
    do_step(TWO, v, sp, lat);
    e = sb_q.pop_front();
    n_checks++;
    if (v !== e.v) begin
      n_fail++;
      $display("FAIL midrst_pre_step: got %h want %h", v, e.v);
    end
    i_in     = TWO;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || v_out !== 32'h0000_0000 || spike !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: got ready %b valid %b v %h spike %b want 1 0 00000000 0",
               in_ready, out_valid, v_out, spike);
    end
    seen_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (out_valid === 1'b1) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_output: got out_valid pulse %b want 0", seen_valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   got;
    int   last;
    int   cyc;
    apply_reset();
    set_cfg('0, '0, 32'h000A_0000, ONE, HALF, 8'd0);
    push_exp(32'h0001_0000, 1'b0);
    push_exp(32'h0001_8000, 1'b0);
    push_exp(32'h0001_C000, 1'b0);
    push_exp(32'h0001_E000, 1'b0);
    got       = 0;
    last      = -1;
    cyc       = 0;
    i_in      = TWO;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (got < 4 && cyc < 60) begin
      cycle();
      cyc++;
      if (out_valid === 1'b1) begin
        e = sb_q.pop_front();
        n_checks++;
        if (v_out !== e.v) begin
          n_fail++;
          $display("FAIL b2b_v_out #%0d: got %h want %h", got, v_out, e.v);
        end
        if (last >= 0) begin
          n_checks++;
          if (cyc - last !== 6) begin
            n_fail++;
            $display("FAIL b2b_spacing #%0d: got %0d cycles want 6", got, cyc - last);
          end
        end
        last = cyc;
        got++;
        if (got == 4) in_valid = 1'b0;
      end
    end
    n_checks++;
    if (got !== 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results want 4", got);
    end
    cycle();
    cycle();
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_after: got ready %b valid %b want 1 0", in_ready, out_valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_step();
    test_threshold_refractory();
    test_sign();
    test_neg_zero();
    test_backpressure();
    test_reset_mid_step();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
